// File: rtl/adc_px_capture_mc.sv
// Multi-channel serial ADC capture: one shared CS/SCLK, per-channel deserialisers,
// byte-lane packing into 32-bit words with a single-entry output register.
module adc_px_capture_mc #(
    parameter int NCH        = 4,
    parameter int ADC_BITS   = 8,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 3,
    parameter int SCLK_DIV   = 2,
    parameter int QUIET_CYC  = 4,
    parameter int PACK       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              flush,
    input  logic              clr_overflow,
    input  logic [NCH-1:0]    miso,
    output logic              cs,
    output logic              sclk,
    output logic              busy,
    output logic              px_valid,
    output logic [NCH*8-1:0]  px_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [NCH*32-1:0] word_data,
    output logic              overflow
);

    localparam int CNT_MAX = (SCLK_DIV > QUIET_CYC) ? SCLK_DIV : QUIET_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int HW      = $clog2(2 * FRAME_BITS + 1);
    localparam int PW      = (PACK > 1) ? $clog2(PACK) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYC - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(2 * FRAME_BITS);
    localparam logic [HW-1:0] H_FIRST    = HW'(2 * LEAD_BITS);
    localparam logic [HW-1:0] H_LAST     = HW'(2 * (LEAD_BITS + ADC_BITS - 1));
    localparam logic [PW-1:0] PACK_LAST  = PW'(PACK - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [HW-1:0]             half_q, half_d;
    logic [NCH*ADC_BITS-1:0]   sh_q, sh_d;
    logic [PW-1:0]             pack_cnt_q, pack_cnt_d;
    logic [NCH*32-1:0]         pack_buf_q, pack_buf_d;
    logic                      cs_d, sclk_d, px_valid_d, word_valid_d, overflow_d;
    logic [NCH*8-1:0]          px_data_d;
    logic [NCH*32-1:0]         word_data_d, word_new;
    logic                      tick, sample, px_done, complete;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        half_d       = half_q;
        cs_d         = cs;
        sclk_d       = sclk;
        sh_d         = sh_q;
        px_valid_d   = 1'b0;
        px_data_d    = px_data;
        pack_cnt_d   = pack_cnt_q;
        pack_buf_d   = pack_buf_q;
        word_valid_d = word_valid;
        word_data_d  = word_data;
        overflow_d   = overflow;
        word_new     = '0;
        sample       = 1'b0;
        px_done      = 1'b0;
        complete     = 1'b0;
        tick         = (cnt_q == DIV_LAST);

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                half_d = '0;
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                if (start) begin
                    state_d = SETUP;
                    cs_d    = 1'b0;
                end
            end
            SETUP: begin
                cs_d   = 1'b0;
                sclk_d = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (tick) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    half_d  = '0;
                    sclk_d  = 1'b0;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk;
                    sample = ~sclk;
                    // Final low half: the return to idle-high is the last sampling rise.
                    if (half_q == HALF_LAST) begin
                        state_d = QUIET;
                        cs_d    = 1'b1;
                        sclk_d  = 1'b1;
                        px_done = 1'b1;
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end
            end
            QUIET: begin
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == QUIET_LAST) begin
                    cnt_d = '0;
                    if (continuous) begin
                        state_d = SETUP;
                        cs_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Rising edges land on even half indices; half/2 is the frame bit number.
        if (sample && half_q >= H_FIRST && half_q <= H_LAST) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                sh_d[ch*ADC_BITS +: ADC_BITS] = (sh_q[ch*ADC_BITS +: ADC_BITS] << 1)
                                              | ADC_BITS'(miso[ch]);
            end
        end

        if (px_done) begin
            px_valid_d = 1'b1;
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                px_data_d[ch*8 +: 8] = 8'(sh_d[ch*ADC_BITS +: ADC_BITS]);
                pack_buf_d[ch*32 + 8*32'(pack_cnt_q) +: 8] = 8'(sh_d[ch*ADC_BITS +: ADC_BITS]);
            end
            if (pack_cnt_q == PACK_LAST || flush) begin
                complete = 1'b1;
            end else begin
                pack_cnt_d = pack_cnt_q + 1'b1;
            end
        end else if (flush && pack_cnt_q != '0) begin
            complete = 1'b1;
        end

        if (complete) begin
            word_new   = pack_buf_d;
            pack_buf_d = '0;
            pack_cnt_d = '0;
        end

        if (clr_overflow) overflow_d = 1'b0;
        if (word_valid && word_ready) word_valid_d = 1'b0;
        if (complete) begin
            if (!word_valid || word_ready) begin
                word_valid_d = 1'b1;
                word_data_d  = word_new;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            half_q     <= '0;
            sh_q       <= '0;
            pack_cnt_q <= '0;
            pack_buf_q <= '0;
            cs         <= 1'b1;
            sclk       <= 1'b1;
            px_valid   <= 1'b0;
            px_data    <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            sh_q       <= sh_d;
            pack_cnt_q <= pack_cnt_d;
            pack_buf_q <= pack_buf_d;
            cs         <= cs_d;
            sclk       <= sclk_d;
            px_valid   <= px_valid_d;
            px_data    <= px_data_d;
            word_valid <= word_valid_d;
            word_data  <= word_data_d;
            overflow   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_adc_px_capture_mc.sv
// Bench for adc_px_capture_mc: serial ADC models on MISO plus a queue-based
// pixel/word reference model checked with immediate assertions.
module tb_adc_px_capture_mc;

    localparam int NCH        = 4;
    localparam int ADC_BITS   = 8;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_BITS  = 3;
    localparam int SCLK_DIV   = 2;
    localparam int QUIET_CYC  = 4;
    localparam int PACK       = 4;
    localparam int CONV_LEN   = 2 * SCLK_DIV * (FRAME_BITS + 1) + QUIET_CYC;

    typedef logic [NCH*8-1:0]  px_t;
    typedef logic [NCH*32-1:0] word_t;

    logic           clk, reset, start, continuous, flush, clr_overflow;
    logic [NCH-1:0] miso;
    logic           cs, sclk, busy, px_valid, word_valid, word_ready, overflow;
    px_t            px_data;
    word_t          word_data;

    int    checks = 0;
    int    errors = 0;
    px_t   exp_q[$];
    px_t   forced_q[$];
    px_t   pend[$];
    px_t   cur_frame;
    int    fcnt = 0;
    int    last_falls = 0;
    logic  m_wv, m_ov;
    word_t m_wd;

    adc_px_capture_mc #(
        .NCH(NCH), .ADC_BITS(ADC_BITS), .FRAME_BITS(FRAME_BITS), .LEAD_BITS(LEAD_BITS),
        .SCLK_DIV(SCLK_DIV), .QUIET_CYC(QUIET_CYC), .PACK(PACK)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .flush(flush),
        .clr_overflow(clr_overflow), .miso(miso), .cs(cs), .sclk(sclk), .busy(busy),
        .px_valid(px_valid), .px_data(px_data), .word_valid(word_valid),
        .word_ready(word_ready), .word_data(word_data), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ADC side: a new conversion value is chosen when CS falls.
    initial begin
        forever begin
            @(negedge cs);
            if (forced_q.size() > 0) begin
                cur_frame = forced_q.pop_front();
            end else begin
                for (int ch = 0; ch < NCH; ch++) cur_frame[ch*8 +: 8] = 8'($urandom);
            end
            exp_q.push_back(cur_frame);
        end
    end

    initial begin
        forever begin
            @(posedge cs);
            last_falls = fcnt;
            fcnt = 0;
        end
    end

    // Frame bit b is driven after SCLK fall b+1; non-data bits carry random junk.
    initial begin
        miso = '0;
        forever begin
            @(negedge sclk);
            if (cs === 1'b0) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (fcnt >= LEAD_BITS && fcnt < LEAD_BITS + ADC_BITS)
                        miso[ch] = cur_frame[ch*8 + ADC_BITS - 1 - (fcnt - LEAD_BITS)];
                    else
                        miso[ch] = 1'($urandom);
                end
                fcnt++;
            end
        end
    end

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic word_t pack_word();
        word_t w = '0;
        for (int k = 0; k < pend.size(); k++)
            for (int ch = 0; ch < NCH; ch++)
                w[ch*32 + 8*k +: 8] = pend[k][ch*8 +: 8];
        return w;
    endfunction

    task automatic model_complete(input logic rdy);
        word_t w = pack_word();
        pend.delete();
        if (!m_wv || rdy) begin
            m_wv = 1'b1;
            m_wd = w;
        end else begin
            m_ov = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_word_valid"}, word_valid, m_wv);
        if (m_wv) check({tag, "_word_data"}, word_data, m_wd);
        check({tag, "_overflow"}, overflow, m_ov);
    endtask

    task automatic check_px(input string tag);
        px_t v;
        if (exp_q.size() == 0) begin
            check({tag, "_px_unexpected"}, px_valid, 1'b0);
        end else begin
            v = exp_q.pop_front();
            check({tag, "_px_data"}, px_data, v);
            if (m_wv && word_ready) m_wv = 1'b0;
            pend.push_back(v);
            if (pend.size() == PACK) model_complete(word_ready);
            check_outputs(tag);
        end
    endtask

    task automatic wait_px(input string tag);
        int n = 0;
        tick();
        while (!px_valid && n < 300) begin
            tick();
            n++;
        end
        if (!px_valid) check({tag, "_px_timeout"}, px_valid, 1'b1);
        else check_px(tag);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_idle_timeout"}, busy, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic convert(input string tag);
        pulse_start();
        wait_px(tag);
        tick();
        check({tag, "_px_pulse"}, px_valid, 1'b0);
        wait_idle(tag);
    endtask

    task automatic do_flush(input string tag);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (m_wv && word_ready) m_wv = 1'b0;
        if (pend.size() > 0) model_complete(word_ready);
        check_outputs(tag);
    endtask

    task automatic take_word(input string tag);
        check({tag, "_take_valid"}, word_valid, 1'b1);
        check({tag, "_take_data"}, word_data, m_wd);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        m_wv = 1'b0;
        check({tag, "_after_take"}, word_valid, 1'b0);
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; continuous = 1'b0; flush = 1'b0;
        clr_overflow = 1'b0; word_ready = 1'b0;
        m_wv = 1'b0; m_ov = 1'b0; m_wd = '0;
        repeat (3) tick();
        check("rst_cs", cs, 1'b1);
        check("rst_sclk", sclk, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_px_valid", px_valid, 1'b0);
        check("rst_px_data", px_data, '0);
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_word_data", word_data, '0);
        check("rst_overflow", overflow, 1'b0);
        reset = 1'b1;
        tick();

        // Four fixed conversions pack into one word, first pixel in lane 0.
        forced_q.push_back({NCH{8'hA5}});
        forced_q.push_back({NCH{8'h3C}});
        forced_q.push_back({NCH{8'hFF}});
        forced_q.push_back({NCH{8'h00}});
        for (int i = 0; i < 4; i++) begin
            convert("t1");
            check("t1_sclk_falls", last_falls, FRAME_BITS + 1);
        end
        check("t1_word_const", word_data, {NCH{32'h00FF3CA5}});
        take_word("t1");

        // Frame length and start-while-busy.
        pulse_start();
        check("t4_cs_low", cs, 1'b0);
        check("t4_sclk_setup", sclk, 1'b1);
        check("t4_busy", busy, 1'b1);
        n = 0;
        while (busy && n < CONV_LEN + 20) begin
            start = (n == 30);
            tick();
            n++;
            if (px_valid) check_px("t4");
        end
        start = 1'b0;
        check("t4_conv_len", n, CONV_LEN);
        repeat (4) tick();
        check("t4_no_restart", busy, 1'b0);
        check("t4_no_extra_frame", exp_q.size(), 0);

        // Partial-word flush; flush with nothing pending is inert.
        do_flush("t3_one");
        take_word("t3_one");
        do_flush("t3_empty");
        check("t3_empty_valid", word_valid, 1'b0);
        forced_q.push_back({NCH{8'h11}});
        forced_q.push_back({NCH{8'h22}});
        convert("t3");
        convert("t3");
        do_flush("t3_two");
        check("t3_word_const", word_data, {NCH{32'h00002211}});
        take_word("t3_two");

        // Transfer and new completion on the same edge: no overflow.
        for (int i = 0; i < 4; i++) convert("t6_a");
        for (int i = 0; i < 3; i++) convert("t6_b");
        pulse_start();
        repeat (2 * SCLK_DIV * (FRAME_BITS + 1) - 1) tick();
        word_ready = 1'b1;
        wait_px("t6_same");
        word_ready = 1'b0;
        check("t6_no_overflow", overflow, 1'b0);
        wait_idle("t6");
        take_word("t6");

        // Continuous mode with a stalled consumer overflows on the second word.
        continuous = 1'b1;
        pulse_start();
        for (int i = 0; i < 2 * PACK; i++) wait_px("t2");
        continuous = 1'b0;
        wait_idle("t2");
        check("t2_frames", exp_q.size(), 0);
        check("t2_overflow_set", overflow, 1'b1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        m_ov = 1'b0;
        check_outputs("t2_clr");
        take_word("t2");

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < PACK; i++) convert("t5_pre");
        pulse_start();
        repeat (21) tick();
        reset = 1'b0;
        #1;
        check("t5_cs", cs, 1'b1);
        check("t5_sclk", sclk, 1'b1);
        check("t5_word_valid", word_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        exp_q.delete();
        pend.delete();
        m_wv = 1'b0;
        m_ov = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < PACK; i++) convert("t5_post");
        take_word("t5_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
